// File: rtl/s_mic_apb_bridge_if.sv
// rtl/s_mic_apb_bridge_if.sv - MIC stream + APB bus bundle for the MIC-to-APB bridge
// Purpose : groups the MIC request/response streams and the APB initiator bus.
// Modports: slave  - bridge view (MIC completer, APB initiator)
//           master - environment view (MIC requester, APB completer)
// Signals : I_TDATA/I_TVALID/I_TREADY/I_TLAST  MIC request stream
//           O_TDATA/O_TVALID/O_TREADY/O_TLAST  MIC response stream
//           PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY  APB bus
interface s_mic_apb_bridge_if #(
    parameter int APB_ADDR_W = 16
);
    logic [63:0]           I_TDATA;
    logic                  I_TVALID;
    logic                  I_TREADY;
    logic                  I_TLAST;
    logic [63:0]           O_TDATA;
    logic                  O_TVALID;
    logic                  O_TREADY;
    logic                  O_TLAST;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [APB_ADDR_W-1:0] PADDR;
    logic [31:0]           PWDATA;
    logic [31:0]           PRDATA;
    logic                  PREADY;

    modport slave (
        input  I_TDATA, I_TVALID, I_TLAST, O_TREADY, PRDATA, PREADY,
        output I_TREADY, O_TDATA, O_TVALID, O_TLAST,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport master (
        output I_TDATA, I_TVALID, I_TLAST, O_TREADY, PRDATA, PREADY,
        input  I_TREADY, O_TDATA, O_TVALID, O_TLAST,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/s_mic_apb_bridge.sv
// rtl/s_mic_apb_bridge.sv - MIC completer that replays request packets as APB transfers
// Purpose : accepts MIC RD/WR packets, splits each 64-bit beat into two 32-bit APB
//           transfers (low word at addr, high word at addr+4), returns a response.
// Ports   : clk      system and APB clock
//           reset_n  asynchronous active-low reset
//           bus      s_mic_apb_bridge_if.slave (MIC request/response streams, APB bus)
// Header  : [63:56] cmd (01 RD, 02 WR; responses 81 read-data, 82 write-ack)
//           [55:48] src, [42:40] len (beats-1), [31:0] byte address
// Option  : APB_TIMEOUT_EN - abandon an ACCESS phase after TIMEOUT_CYCLES PREADY-low cycles
module s_mic_apb_bridge #(
    parameter int APB_ADDR_W     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    s_mic_apb_bridge_if.slave  bus
);
    localparam logic [7:0] CMD_RD  = 8'h01;
    localparam logic [7:0] CMD_WR  = 8'h02;
    localparam logic [7:0] RSP_RD  = 8'h81;
    localparam logic [7:0] RSP_WR  = 8'h82;

    typedef enum logic [2:0] {
        S_IDLE, S_DRAIN, S_WDATA, S_SETUP, S_ACCESS, S_WACK, S_RHDR, S_RDATA
    } state_t;

    state_t                r_state, w_next;
    logic                  r_alive;      // keeps I_TREADY low in the first cycle out of reset
    logic                  r_is_wr;      // also selects where DRAIN exits (WACK vs IDLE)
    logic                  r_half;       // 0: low word transfer, 1: high word transfer
    logic                  r_last_seen;  // request TLAST already consumed
    logic [3:0]            r_beat;
    logic [2:0]            r_len;
    logic [7:0]            r_src;
    logic [APB_ADDR_W-1:0] r_base;
    logic [63:0]           r_buf;        // write data beat or assembled read data

    logic                  w_i_tready, w_o_tvalid, w_o_tlast, w_psel, w_penable;
    logic [63:0]           w_o_tdata;
    logic                  w_in_hs, w_out_hs, w_done, w_tmo, w_xfer, w_rd_last;
    logic [7:0]            w_cmd;
    logic [31:0]           w_rdata;
    logic                  w_unused;

    assign w_cmd     = bus.I_TDATA[63:56];
    assign w_in_hs   = bus.I_TVALID && w_i_tready;
    assign w_out_hs  = w_o_tvalid && bus.O_TREADY;
    assign w_xfer    = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign w_rd_last = (r_beat == {1'b0, r_len});

`ifdef APB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                  r_tmo <= '0;
        else if (r_state == S_ACCESS && !bus.PREADY)   r_tmo <= r_tmo + 1'b1;
        else                                           r_tmo <= '0;
    end

    assign w_tmo    = (r_state == S_ACCESS) && !bus.PREADY && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
    assign w_unused = ^bus.I_TDATA;
`else
    assign w_tmo    = 1'b0;
    assign w_unused = ^{bus.I_TDATA, TIMEOUT_CYCLES[0]};
`endif

    // An abandoned transfer completes like a normal one; read data is poisoned.
    assign w_done  = bus.PREADY || w_tmo;
    assign w_rdata = bus.PREADY ? bus.PRDATA : 32'hDEADBEEF;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_i_tready = 1'b0;
        w_o_tvalid = 1'b0;
        w_o_tdata  = '0;
        w_o_tlast  = 1'b0;
        w_psel     = 1'b0;
        w_penable  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_i_tready = r_alive;
                if (w_in_hs) begin
                    if (w_cmd == CMD_WR)      w_next = bus.I_TLAST ? S_WACK : S_WDATA;
                    else if (w_cmd == CMD_RD) w_next = S_RHDR;
                    else                      w_next = bus.I_TLAST ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_i_tready = 1'b1;
                if (w_in_hs && bus.I_TLAST) w_next = r_is_wr ? S_WACK : S_IDLE;
            end
            S_WDATA: begin
                w_i_tready = 1'b1;
                if (w_in_hs) w_next = S_SETUP;
            end
            S_SETUP: begin
                w_psel = 1'b1;
                w_next = S_ACCESS;
            end
            S_ACCESS: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
                if (w_done) begin
                    if (!r_half)        w_next = S_SETUP;
                    else if (!r_is_wr)  w_next = S_RDATA;
                    // r_beat == r_len here means this was beat len+1 of the packet
                    else if (r_beat == {1'b0, r_len}) w_next = r_last_seen ? S_WACK : S_DRAIN;
                    else                w_next = r_last_seen ? S_WACK : S_WDATA;
                end
            end
            S_WACK: begin
                w_o_tvalid = 1'b1;
                w_o_tdata  = {RSP_WR, r_src, 48'h0};
                w_o_tlast  = 1'b1;
                if (w_out_hs) w_next = S_IDLE;
            end
            S_RHDR: begin
                w_o_tvalid = 1'b1;
                w_o_tdata  = {RSP_RD, r_src, 5'b0, r_len, 40'h0};
                if (w_out_hs) w_next = S_SETUP;
            end
            S_RDATA: begin
                w_o_tvalid = 1'b1;
                w_o_tdata  = r_buf;
                w_o_tlast  = w_rd_last;
                if (w_out_hs) w_next = w_rd_last ? S_IDLE : S_SETUP;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alive     <= 1'b0;
            r_is_wr     <= 1'b0;
            r_half      <= 1'b0;
            r_last_seen <= 1'b0;
            r_beat      <= '0;
            r_len       <= '0;
            r_src       <= '0;
            r_base      <= '0;
            r_buf       <= '0;
        end else begin
            r_alive <= 1'b1;
            if (r_state == S_IDLE && w_in_hs) begin
                r_is_wr     <= (w_cmd == CMD_WR);
                r_src       <= bus.I_TDATA[55:48];
                r_len       <= bus.I_TDATA[42:40];
                r_base      <= {bus.I_TDATA[APB_ADDR_W-1:3], 3'b000};
                r_beat      <= '0;
                r_half      <= 1'b0;
                r_last_seen <= bus.I_TLAST;
            end
            if (r_state == S_WDATA && w_in_hs) begin
                r_buf       <= bus.I_TDATA;
                r_last_seen <= bus.I_TLAST;
            end
            if (r_state == S_ACCESS && w_done) begin
                r_half <= ~r_half;
                if (!r_is_wr) begin
                    if (r_half) r_buf[63:32] <= w_rdata;
                    else        r_buf[31:0]  <= w_rdata;
                end else if (r_half) begin
                    r_beat <= r_beat + 1'b1;
                end
            end
            if (r_state == S_RDATA && w_out_hs) r_beat <= r_beat + 1'b1;
        end
    end

    assign bus.I_TREADY = w_i_tready;
    assign bus.O_TVALID = w_o_tvalid;
    assign bus.O_TDATA  = w_o_tdata;
    assign bus.O_TLAST  = w_o_tlast;
    assign bus.PSEL     = w_psel;
    assign bus.PENABLE  = w_penable;
    assign bus.PWRITE   = w_xfer && r_is_wr;
    // byte offset 8*beat + 4*half, wrapping at the APB address width
    assign bus.PADDR    = w_xfer ? r_base + APB_ADDR_W'({r_beat, r_half, 2'b00}) : '0;
    assign bus.PWDATA   = (w_xfer && r_is_wr) ? (r_half ? r_buf[63:32] : r_buf[31:0]) : 32'h0;
endmodule

// File: tb/tb_s_mic_apb_bridge.sv
// tb/tb_s_mic_apb_bridge.sv - scoreboard bench for s_mic_apb_bridge
module tb_s_mic_apb_bridge;
    logic clk;
    logic reset_n;

    s_mic_apb_bridge_if #(.APB_ADDR_W(16)) bus ();

    s_mic_apb_bridge #(.APB_ADDR_W(16), .TIMEOUT_CYCLES(255)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct { bit wr; logic [15:0] addr; logic [31:0] data; } apb_t;
    typedef struct { logic last; logic [63:0] data; } rsp_t;

    apb_t apb_q[$];
    rsp_t rsp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   stall_max = 0;
    bit   stuck = 0;
    int   remaining = 0;
    logic [15:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_wr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [7:0] cmd, input logic [7:0] src,
                                        input logic [2:0] len, input logic [31:0] addr);
        return {cmd, src, 5'b0, len, 8'h0, addr};
    endfunction

    function automatic logic [31:0] rd_model(input logic [15:0] a);
        return {16'h0, a} ^ 32'hA5A50000;
    endfunction

    task automatic push_wr(input logic [15:0] a, input logic [63:0] d);
        logic [15:0] a4;
        a4 = a + 16'd4;
        apb_q.push_back('{1'b1, a, d[31:0]});
        apb_q.push_back('{1'b1, a4, d[63:32]});
    endtask

    task automatic push_rd(input logic [15:0] a, input logic last);
        logic [15:0] a4;
        a4 = a + 16'd4;
        apb_q.push_back('{1'b0, a, 32'h0});
        apb_q.push_back('{1'b0, a4, 32'h0});
        rsp_q.push_back('{last, {rd_model(a4), rd_model(a)}});
    endtask

    task automatic send(input logic [63:0] d, input logic last);
        int  n;
        logic ok;
        n = 0;
        ok = 1'b0;
        bus.I_TDATA  = d;
        bus.I_TLAST  = last;
        bus.I_TVALID = 1'b1;
        while (!ok && n < 3000) begin
            @(negedge clk);
            ok = bus.I_TREADY;
            @(posedge clk);
            #1;
            n++;
        end
        bus.I_TVALID = 1'b0;
        bus.I_TLAST  = 1'b0;
        chk("send_accept", {63'h0, ok}, 64'h1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((apb_q.size() != 0 || rsp_q.size() != 0 || bus.I_TREADY !== 1'b1) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({"done_", tag}, {63'h0, n < 5000}, 64'h1);
    endtask

    // APB completer: PREADY chosen on the falling edge for the next rising edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            bus.PREADY = 1'b0;
            remaining  = 0;
        end else if (bus.PSEL && !bus.PENABLE) begin
            remaining  = $urandom_range(0, stall_max);
            s_addr     = bus.PADDR;
            s_wdata    = bus.PWDATA;
            s_wr       = bus.PWRITE;
            bus.PREADY = 1'b0;
        end else if (bus.PSEL && bus.PENABLE) begin
            chk("apb_paddr_stable", {48'h0, bus.PADDR}, {48'h0, s_addr});
            chk("apb_pwdata_stable", {32'h0, bus.PWDATA}, {32'h0, s_wdata});
            chk("apb_pwrite_stable", {63'h0, bus.PWRITE}, {63'h0, s_wr});
            if (stuck) begin
                bus.PREADY = 1'b0;
            end else if (remaining == 0) begin
                apb_t e;
                bus.PREADY = 1'b1;
                bus.PRDATA = rd_model(bus.PADDR);
                if (apb_q.size() == 0) begin
                    chk("apb_unexpected", {48'h0, bus.PADDR}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = apb_q.pop_front();
                    chk("apb_pwrite", {63'h0, bus.PWRITE}, {63'h0, e.wr});
                    chk("apb_paddr", {48'h0, bus.PADDR}, {48'h0, e.addr});
                    if (e.wr) chk("apb_pwdata", {32'h0, bus.PWDATA}, {32'h0, e.data});
                end
            end else begin
                remaining--;
                bus.PREADY = 1'b0;
            end
        end else begin
            bus.PREADY = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset_n && bus.O_TVALID && bus.O_TREADY) begin
            rsp_t e;
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", bus.O_TDATA, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = rsp_q.pop_front();
                chk("rsp_tdata", bus.O_TDATA, e.data);
                chk("rsp_tlast", {63'h0, bus.O_TLAST}, {63'h0, e.last});
            end
        end
    end

    initial begin
        logic [63:0] d;
        logic [63:0] cap;
        logic [15:0] a;
        int n;

        bus.I_TDATA  = '0;
        bus.I_TVALID = 1'b0;
        bus.I_TLAST  = 1'b0;
        bus.O_TREADY = 1'b1;
        bus.PRDATA   = '0;
        reset_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_i_tready", {63'h0, bus.I_TREADY}, 64'h0);
        chk("rst_o_tvalid", {63'h0, bus.O_TVALID}, 64'h0);
        chk("rst_o_tdata", bus.O_TDATA, 64'h0);
        chk("rst_psel", {62'h0, bus.PSEL, bus.PENABLE}, 64'h0);
        chk("rst_paddr", {48'h0, bus.PADDR}, 64'h0);
        chk("rst_pwdata", {32'h0, bus.PWDATA}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // single-beat write
        push_wr(16'h0010, 64'h11223344_55667788);
        rsp_q.push_back('{1'b1, {8'h82, 8'h05, 48'h0}});
        send(hdr(8'h02, 8'h05, 3'd0, 32'h0010), 1'b0);
        send(64'h11223344_55667788, 1'b1);
        wait_done("wr1");

        // four-beat read
        rsp_q.push_back('{1'b0, {8'h81, 8'h09, 5'b0, 3'd3, 40'h0}});
        for (int i = 0; i < 4; i++) push_rd(16'h0100 + 16'(8 * i), i == 3);
        send(hdr(8'h01, 8'h09, 3'd3, 32'h0100), 1'b1);
        wait_done("rd4");

        // eight-beat write with random PREADY stalls
        stall_max = 5;
        rsp_q.push_back('{1'b1, {8'h82, 8'h11, 48'h0}});
        send(hdr(8'h02, 8'h11, 3'd7, 32'h0300), 1'b0);
        for (int i = 0; i < 8; i++) begin
            d = {$urandom, $urandom};
            push_wr(16'h0300 + 16'(8 * i), d);
            send(d, i == 7);
        end
        wait_done("wr8_stall");
        stall_max = 0;

        // response backpressure on a read data beat
        rsp_q.push_back('{1'b0, {8'h81, 8'h03, 5'b0, 3'd1, 40'h0}});
        push_rd(16'h0200, 1'b0);
        push_rd(16'h0208, 1'b1);
        send(hdr(8'h01, 8'h03, 3'd1, 32'h0200), 1'b1);
        n = 0;
        while (rsp_q.size() != 2 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        bus.O_TREADY = 1'b0;
        chk("bp_hdr_seen", {63'h0, n < 1000}, 64'h1);
        n = 0;
        while (bus.O_TVALID !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", {63'h0, n < 1000}, 64'h1);
        cap = bus.O_TDATA;
        repeat (10) begin
            @(negedge clk);
            chk("bp_o_tvalid", {63'h0, bus.O_TVALID}, 64'h1);
            chk("bp_o_tdata", bus.O_TDATA, cap);
            chk("bp_no_psel", {63'h0, bus.PSEL}, 64'h0);
        end
        @(posedge clk);
        #1;
        bus.O_TREADY = 1'b1;
        wait_done("rd_bp");

        // unknown command drains with no response and no APB traffic
        send(hdr(8'h07, 8'h01, 3'd1, 32'h0040), 1'b0);
        send(64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
        send(64'hBBBB_BBBB_BBBB_BBBB, 1'b1);
        wait_done("unknown");

        // early TLAST: len=3 but only two beats
        rsp_q.push_back('{1'b1, {8'h82, 8'h21, 48'h0}});
        send(hdr(8'h02, 8'h21, 3'd3, 32'h0700), 1'b0);
        push_wr(16'h0700, 64'h0101_0202_0303_0404);
        send(64'h0101_0202_0303_0404, 1'b0);
        push_wr(16'h0708, 64'h0505_0606_0707_0808);
        send(64'h0505_0606_0707_0808, 1'b1);
        wait_done("early_last");

        // excess beats beyond len+1 are drained
        rsp_q.push_back('{1'b1, {8'h82, 8'h22, 48'h0}});
        send(hdr(8'h02, 8'h22, 3'd0, 32'h0800), 1'b0);
        push_wr(16'h0800, 64'hCAFE_0001_CAFE_0002);
        send(64'hCAFE_0001_CAFE_0002, 1'b0);
        send(64'h1234_5678_9ABC_DEF0, 1'b0);
        send(64'h0FED_CBA9_8765_4321, 1'b1);
        wait_done("excess");

        // address wrap; upper bits ignored and bits [2:0] forced low
        a = 16'hFFF8;
        rsp_q.push_back('{1'b1, {8'h82, 8'h33, 48'h0}});
        send(hdr(8'h02, 8'h33, 3'd1, 32'h0001_FFFB), 1'b0);
        push_wr(a, 64'h9999_8888_7777_6666);
        send(64'h9999_8888_7777_6666, 1'b0);
        push_wr(16'h0000, 64'h5555_4444_3333_2222);
        send(64'h5555_4444_3333_2222, 1'b1);
        wait_done("wrap");

        // asynchronous reset during ACCESS of a write
        stuck = 1'b1;
        send(hdr(8'h02, 8'h44, 3'd0, 32'h0500), 1'b0);
        send(64'hDDDD_DDDD_EEEE_EEEE, 1'b1);
        n = 0;
        while (!(bus.PSEL && bus.PENABLE) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_access_seen", {63'h0, n < 1000}, 64'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_psel", {63'h0, bus.PSEL}, 64'h0);
        chk("arst_penable", {63'h0, bus.PENABLE}, 64'h0);
        chk("arst_pwrite", {63'h0, bus.PWRITE}, 64'h0);
        chk("arst_o_tvalid", {63'h0, bus.O_TVALID}, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        stuck   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rsp_q.push_back('{1'b1, {8'h82, 8'h45, 48'h0}});
        send(hdr(8'h02, 8'h45, 3'd0, 32'h0600), 1'b0);
        push_wr(16'h0600, 64'h1357_9BDF_2468_ACE0);
        send(64'h1357_9BDF_2468_ACE0, 1'b1);
        wait_done("after_reset");

`ifdef APB_TIMEOUT_EN
        // PREADY stuck low: both words time out and read as DEADBEEF
        stuck = 1'b1;
        rsp_q.push_back('{1'b0, {8'h81, 8'h55, 5'b0, 3'd0, 40'h0}});
        rsp_q.push_back('{1'b1, 64'hDEADBEEF_DEADBEEF});
        send(hdr(8'h01, 8'h55, 3'd0, 32'h0900), 1'b1);
        wait_done("timeout");
        stuck = 1'b0;
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
